// File: rtl/maskmul_chk_pkg.sv
// Shared types and GF(2^2) arithmetic for the masked-multiplier response checker.
package maskmul_chk_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_WARMUP = 3'd1;
    localparam logic [2:0] ST_CHECK  = 3'd2;
    localparam logic [2:0] ST_DONE   = 3'd3;
    localparam logic [2:0] ST_FAIL   = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        WARMUP = ST_WARMUP,
        CHECK  = ST_CHECK,
        DONE   = ST_DONE,
        FAIL   = ST_FAIL
    } chk_state_e;

    // x^2 folds back as x+1 for the field polynomial x^2+x+1
    localparam logic [1:0] GF_POLY = 2'b11;

    // Sliced down to the counter width by the user
    localparam logic [31:0] FIRST_FAIL_NONE = 32'hFFFF_FFFF;

    function automatic logic [1:0] gf4_mul(input logic [1:0] a, input logic [1:0] b);
        logic [2:0] prod;
        prod = {a[1] & b[1], (a[1] & b[0]) ^ (a[0] & b[1]), a[0] & b[0]};
        return prod[2] ? (prod[1:0] ^ GF_POLY) : prod[1:0];
    endfunction

endpackage

// File: rtl/maskmul_chk_delay.sv
// LATENCY-deep shift register of {valid, expected qm}; aligns the golden result with the DUT output.
module maskmul_chk_delay
    import maskmul_chk_pkg::*;
#(
    parameter int LATENCY = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       clr,
    input  logic       in_vld,
    input  logic [1:0] in_qm,
    output logic       tail_vld,
    output logic [1:0] tail_qm,
    output logic       near_vld
);

    logic [LATENCY-1:0]      vld_line;
    logic [LATENCY-1:0][1:0] qm_line;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld_line <= '0;
            qm_line  <= '0;
        end else if (clr) begin
            vld_line <= '0;
            qm_line  <= '0;
        end else begin
            vld_line[0] <= in_vld;
            qm_line[0]  <= in_qm;
            for (int i = 1; i < LATENCY; i++) begin
                vld_line[i] <= vld_line[i-1];
                qm_line[i]  <= qm_line[i-1];
            end
        end
    end

    assign tail_vld = vld_line[LATENCY-1];
    assign tail_qm  = qm_line[LATENCY-1];

    // Valid that lands in the tail on the next edge; lets the FSM enter CHECK in step with it
    generate
        if (LATENCY == 1) begin : g_near_in
            assign near_vld = in_vld;
        end else begin : g_near_line
            assign near_vld = vld_line[LATENCY-2];
        end
    endgenerate

endmodule

// File: rtl/maskmul_response_checker.sv
// Recomputes the masked GF(2^2) product, aligns it to the DUT latency and scores the DUT output.
// Optional macro MASKMUL_CHK_STOP_ON_FAIL_EN: stop the run in FAIL on the first mismatch.
module maskmul_response_checker
    import maskmul_chk_pkg::*;
#(
    parameter int LATENCY    = 1,
    parameter int NUM_CHECKS = 16,
    parameter int CNT_W      = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       am,
    input  logic [1:0]       bm,
    input  logic [1:0]       ma,
    input  logic [1:0]       mb,
    input  logic [1:0]       mq,
    input  logic [1:0]       qm_dut,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] mismatch_count,
    output logic [CNT_W-1:0] check_count,
    output logic [CNT_W-1:0] first_fail_idx
);

`ifdef MASKMUL_CHK_STOP_ON_FAIL_EN
    localparam bit STOP_ON_FAIL = 1'b1;
`else
    localparam bit STOP_ON_FAIL = 1'b0;
`endif

    localparam logic [CNT_W-1:0] NONE_IDX = FIRST_FAIL_NONE[CNT_W-1:0];

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    chk_state_e state, state_nxt;
    logic [1:0] exp_qm;
    logic       run_start;
    logic       tail_vld, near_vld;
    logic [1:0] tail_qm;
    logic       compare_en, mismatch, last_check;

    assign exp_qm    = gf4_mul(am ^ ma, bm ^ mb) ^ mq;
    assign busy      = (state == WARMUP) || (state == CHECK);
    assign done      = (state == DONE) || (state == FAIL);
    assign pass      = done && (mismatch_count == '0);
    assign run_start = start && !busy;

    maskmul_chk_delay #(.LATENCY(LATENCY)) u_delay (
        .clock    (clock),
        .reset    (reset),
        .clr      (run_start),
        .in_vld   (busy),
        .in_qm    (exp_qm),
        .tail_vld (tail_vld),
        .tail_qm  (tail_qm),
        .near_vld (near_vld)
    );

    assign compare_en = (state == CHECK) && tail_vld;
    assign mismatch   = compare_en && (tail_qm != qm_dut);
    assign last_check = (int'(check_count) + 1) >= NUM_CHECKS;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE, FAIL: if (start) state_nxt = WARMUP;
            WARMUP:           if (near_vld) state_nxt = CHECK;
            CHECK: begin
                if (compare_en && last_check) state_nxt = DONE;
                // Mismatch overrides the final-check exit so a late failure still lands in FAIL
                if (STOP_ON_FAIL && mismatch) state_nxt = FAIL;
            end
            default:          state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            check_count    <= '0;
            mismatch_count <= '0;
            first_fail_idx <= NONE_IDX;
        end else if (run_start) begin
            check_count    <= '0;
            mismatch_count <= '0;
            first_fail_idx <= NONE_IDX;
        end else if (compare_en) begin
            check_count <= sat_inc(check_count);
            if (mismatch) begin
                mismatch_count <= sat_inc(mismatch_count);
                if (first_fail_idx == NONE_IDX) first_fail_idx <= check_count;
            end
        end
    end

endmodule

// File: tb/tb_maskmul_response_checker.sv
// Randomized bench for maskmul_response_checker: two instances (latency 1 and 3) scored against a time-based model.
module tb_maskmul_response_checker;

`ifdef MASKMUL_CHK_STOP_ON_FAIL_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    localparam int L0 = 1, N0 = 4, L1 = 3, N1 = 6;
    localparam int NONE = 255;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic [1:0] am = '0, bm = '0, ma = '0, mb = '0, mq = '0;
    logic [1:0] qm_dut [2];

    logic       busy0, done0, pass0, busy1, done1, pass1;
    logic [7:0] mmc0, chc0, ffi0, mmc1, chc1, ffi1;

    maskmul_response_checker #(.LATENCY(L0), .NUM_CHECKS(N0), .CNT_W(8)) u0 (
        .clock(clock), .reset(reset), .start(start), .am(am), .bm(bm), .ma(ma), .mb(mb), .mq(mq),
        .qm_dut(qm_dut[0]), .busy(busy0), .done(done0), .pass(pass0),
        .mismatch_count(mmc0), .check_count(chc0), .first_fail_idx(ffi0));

    maskmul_response_checker #(.LATENCY(L1), .NUM_CHECKS(N1), .CNT_W(8)) u1 (
        .clock(clock), .reset(reset), .start(start), .am(am), .bm(bm), .ma(ma), .mb(mb), .mq(mq),
        .qm_dut(qm_dut[1]), .busy(busy1), .done(done1), .pass(pass1),
        .mismatch_count(mmc1), .check_count(chc1), .first_fail_idx(ffi1));

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // GF(4) multiplication table: elements 0,1,x,x+1 encoded 0..3
    logic [1:0] mul_tbl [16] = '{2'd0, 2'd0, 2'd0, 2'd0,
                                 2'd0, 2'd1, 2'd2, 2'd3,
                                 2'd0, 2'd2, 2'd3, 2'd1,
                                 2'd0, 2'd3, 2'd1, 2'd2};

    function automatic logic [1:0] golden(input logic [1:0] am_i, input logic [1:0] bm_i,
                                          input logic [1:0] ma_i, input logic [1:0] mb_i,
                                          input logic [1:0] mq_i);
        logic [3:0] idx;
        idx = {am_i ^ ma_i, bm_i ^ mb_i};
        return mul_tbl[idx] ^ mq_i;
    endfunction

    // Model: phase 0 idle, 1 running, 2 done, 3 failed; k = edges since the start edge
    int lat [2] = '{L0, L1};
    int nch [2] = '{N0, N1};
    int cyc = 0;
    logic [1:0] gold [64];
    int m_phase [2], m_k [2], m_chk [2], m_mm [2], m_ff [2];

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                m_phase[i] = 0; m_k[i] = 0; m_chk[i] = 0; m_mm[i] = 0; m_ff[i] = NONE;
            end
        end else begin
            cyc++;
            gold[cyc % 64] = golden(am, bm, ma, mb, mq);
            for (int i = 0; i < 2; i++) begin
                if (m_phase[i] == 1) begin
                    m_k[i]++;
                    if (m_k[i] > lat[i]) begin
                        automatic bit bad = (gold[(cyc - lat[i]) % 64] != qm_dut[i]);
                        if (bad) begin
                            if (m_ff[i] == NONE) m_ff[i] = m_chk[i];
                            if (m_mm[i] < 255) m_mm[i]++;
                        end
                        if (m_chk[i] < 255) m_chk[i]++;
                        if (STOP && bad) m_phase[i] = 3;
                        else if (m_chk[i] >= nch[i]) m_phase[i] = 2;
                    end
                end else if (start) begin
                    m_phase[i] = 1; m_k[i] = 0; m_chk[i] = 0; m_mm[i] = 0; m_ff[i] = NONE;
                end
            end
        end
    end

    bit cmp_en = 1'b0;

    task automatic cmp_inst(input int i, input logic b, input logic d, input logic p,
                            input logic [7:0] mm, input logic [7:0] ch, input logic [7:0] ff);
        chk($sformatf("u%0d.busy", i), b, m_phase[i] == 1);
        chk($sformatf("u%0d.done", i), d, m_phase[i] >= 2);
        chk($sformatf("u%0d.pass", i), p, (m_phase[i] == 2) && (m_mm[i] == 0));
        chk($sformatf("u%0d.mismatch_count", i), mm, m_mm[i]);
        chk($sformatf("u%0d.check_count", i), ch, m_chk[i]);
        chk($sformatf("u%0d.first_fail_idx", i), ff, m_ff[i]);
    endtask

    always @(negedge clock) begin
        if (cmp_en) begin
            cmp_inst(0, busy0, done0, pass0, mmc0, chc0, ffi0);
            cmp_inst(1, busy1, done1, pass1, mmc1, chc1, ffi1);
        end
    end

    // Stimulus control: stim_rand picks random operands; bad_mode 0 none, 1 at inj_idx, 2 random
    bit stim_rand = 1'b0;
    int bad_mode = 0;
    int inj_idx = 0;

    task automatic drive_cycle();
        @(negedge clock);
        if (stim_rand) begin
            am = 2'($urandom); bm = 2'($urandom); ma = 2'($urandom);
            mb = 2'($urandom); mq = 2'($urandom);
        end
        for (int i = 0; i < 2; i++) begin
            if (m_phase[i] == 1 && m_k[i] + 1 > lat[i]) begin
                automatic bit corrupt = (bad_mode == 1 && m_chk[i] == inj_idx) ||
                                        (bad_mode == 2 && $urandom_range(0, 4) == 0);
                qm_dut[i] = gold[(cyc + 1 - lat[i]) % 64] ^ (corrupt ? 2'b01 : 2'b00);
            end else begin
                qm_dut[i] = 2'($urandom);
            end
        end
    endtask

    task automatic pulse_start();
        drive_cycle();
        start = 1'b1;
        drive_cycle();
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!(done0 && done1) && n < 200) begin
            drive_cycle();
            n++;
        end
        chk("wait_done_timeout", n < 200, 1);
    endtask

    initial begin
        qm_dut[0] = '0;
        qm_dut[1] = '0;
        repeat (3) drive_cycle();
        cmp_en = 1'b1;
        chk("reset.busy", busy0, 0);
        chk("reset.done", done0, 0);
        chk("reset.pass", pass0, 0);
        chk("reset.check_count", chc0, 0);
        chk("reset.mismatch_count", mmc0, 0);
        chk("reset.first_fail_idx", ffi0, 8'hFF);
        #2 reset = 1'b0;

        chk("model.gold_2x2", golden(2'b10, 2'b10, 2'b00, 2'b00, 2'b00), 3);
        chk("model.gold_masked", golden(2'b01, 2'b00, 2'b10, 2'b11, 2'b01), 3);

        // Unmasked 2*2 with an echoing DUT: done exactly LATENCY+NUM_CHECKS edges after start
        am = 2'b10; bm = 2'b10; ma = 2'b00; mb = 2'b00; mq = 2'b00;
        pulse_start();
        repeat (4) drive_cycle();
        chk("s1.u0_done_early", done0, 0);
        drive_cycle();
        chk("s1.u0_done_on_time", done0, 1);
        repeat (3) drive_cycle();
        chk("s1.u1_done_early", done1, 0);
        drive_cycle();
        chk("s1.u1_done_on_time", done1, 1);
        chk("s1.u0_pass", pass0, 1);
        chk("s1.u0_mismatch_count", mmc0, 0);
        chk("s1.u0_first_fail_idx", ffi0, 8'hFF);
        chk("s1.u0_check_count", chc0, 4);
        chk("s1.u1_check_count", chc1, 6);

        // Nonzero masks; start issued from DONE clears the counters
        am = 2'b01; ma = 2'b10; bm = 2'b00; mb = 2'b11; mq = 2'b01;
        pulse_start();
        chk("s2.restart_busy", busy0, 1);
        chk("s2.restart_check_count", chc0, 0);
        wait_done();
        chk("s2.good_pass", pass0, 1);
        chk("s2.good_mismatch_count", mmc0, 0);
        bad_mode = 1; inj_idx = 0;
        pulse_start();
        wait_done();
        chk("s2.bad_mismatch_count", mmc0, 1);
        chk("s2.bad_first_fail_idx", ffi0, 0);
        chk("s2.bad_pass", pass0, 0);

        // One wrong sample at index 2 with random stimulus
        stim_rand = 1'b1; bad_mode = 1; inj_idx = 2;
        pulse_start();
        wait_done();
        chk("s3.u0_done", done0, 1);
        chk("s3.u0_pass", pass0, 0);
        chk("s3.u0_mismatch_count", mmc0, 1);
        chk("s3.u0_first_fail_idx", ffi0, 2);
        chk("s3.u0_check_count", chc0, STOP ? 3 : N0);
        chk("s3.u1_first_fail_idx", ffi1, 2);
        chk("s3.u1_check_count", chc1, STOP ? 3 : N1);

        // start while busy is ignored
        bad_mode = 0;
        pulse_start();
        repeat (2) drive_cycle();
        start = 1'b1;
        drive_cycle();
        start = 1'b0;
        chk("s6.busy_start_ignored", chc0, 2);
        chk("s6.still_busy", busy0, 1);
        wait_done();
        chk("s6.u0_pass", pass0, 1);
        chk("s6.u1_pass", pass1, 1);

        // Asynchronous reset in the middle of CHECK
        pulse_start();
        repeat (4) drive_cycle();
        #2 reset = 1'b1;
        #1;
        chk("s5.reset_busy0", busy0, 0);
        chk("s5.reset_busy1", busy1, 0);
        chk("s5.reset_done1", done1, 0);
        chk("s5.reset_check_count1", chc1, 0);
        chk("s5.reset_mismatch_count0", mmc0, 0);
        chk("s5.reset_first_fail_idx1", ffi1, 8'hFF);
        drive_cycle();
        #2 reset = 1'b0;
        pulse_start();
        wait_done();
        chk("s5.fresh_pass0", pass0, 1);
        chk("s5.fresh_pass1", pass1, 1);

        // Random runs with random corruption, checked every cycle by the model
        bad_mode = 2;
        for (int r = 0; r < 8; r++) begin
            repeat ($urandom_range(0, 3)) drive_cycle();
            pulse_start();
            wait_done();
        end

        repeat (2) drive_cycle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
